// File: rtl/rtr_route_hold_pkg.sv
// Shared router definitions used by the route holding stage, the route
// filter and the VC allocator.
//   - default routing dimensions (ports, resource classes, route FIFO depth)
//   - per-VC route control FSM state encoding
//   - bit positions inside the route holding stage error vector
package rtr_route_hold_pkg;

    // Routing constants
    localparam int NUM_PORTS            = 5;
    localparam int NUM_RESOURCE_CLASSES = 2;
    localparam int ROUTE_FIFO_DEPTH     = 2;

    // Per-VC route control state
    typedef enum logic [1:0] {
        RH_IDLE    = 2'd0,   // no packet route queued
        RH_WAIT_VC = 2'd1,   // route presented, waiting for an output VC
        RH_ACTIVE  = 2'd2    // VC held, packet flits draining
    } rh_state_e;

    // Error vector layout
    localparam int ERR_W          = 3;
    localparam int ERR_OVERFLOW   = 0;  // head arrived with route FIFO full
    localparam int ERR_UNDERFLOW  = 1;  // tail left with no route queued
    localparam int ERR_TAIL_NO_VC = 2;  // tail left before a VC was granted

endpackage

// File: rtl/rtr_route_fifo.sv
// Small register FIFO holding packet routes.
//   clk, reset      clock, asynchronous active-low reset
//   push, push_data write request and data
//   pop             read request (removes the entry shown on pop_data)
//   pop_data        current head entry (registered storage, no bypass)
//   full, empty     occupancy flags
//   count           number of stored entries
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module rtr_route_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/rtr_route_hold.sv
// Per-input-VC route holding stage, upstream of the route filter.
// Captures the lookahead route of each arriving head flit, queues it, and
// presents the route of the packet at the head of the VC buffer until that
// packet's tail leaves. Also sequences the VC allocation request.
//   clk, reset                 clock, asynchronous active-low reset
//   flit_valid_in/head_in      flit written into the VC buffer / is a head
//   route_in_op/route_in_orc   one-hot lookahead port / resource class
//   vc_gnt                     output VC granted to this input VC
//   flit_sent/flit_sent_tail   flit left the buffer / it was a tail
//   route_valid/op/orc         held route of the current packet
//   vc_req                     VC allocation request for the current packet
//   route_count                queued routes including the current one
//   errors                     one-cycle pulses: overflow, underflow,
//                              tail sent without VC
//   dbg_state                  control FSM state
// Handshake: a head is accepted whenever flit_valid_in & flit_head_in is
// high (no backpressure); a packet ends when flit_sent & flit_sent_tail is
// high; vc_gnt only counts while vc_req is high. All outputs come from
// flops, so there is no input-to-output combinational path.
module rtr_route_hold
    import rtr_route_hold_pkg::*;
#(
    parameter int num_ports            = NUM_PORTS,
    parameter int num_resource_classes = NUM_RESOURCE_CLASSES,
    parameter int route_fifo_depth     = ROUTE_FIFO_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flit_valid_in,
    input  logic                                   flit_head_in,
    input  logic [num_ports-1:0]                   route_in_op,
    input  logic [num_resource_classes-1:0]        route_in_orc,
    input  logic                                   vc_gnt,
    input  logic                                   flit_sent,
    input  logic                                   flit_sent_tail,
    output logic                                   route_valid,
    output logic [num_ports-1:0]                   route_op,
    output logic [num_resource_classes-1:0]        route_orc,
    output logic                                   vc_req,
    output logic [$clog2(route_fifo_depth+1)-1:0]  route_count,
    output logic [ERR_W-1:0]                       errors,
    output rh_state_e                              dbg_state
);

    localparam int RW    = num_ports + num_resource_classes;
    localparam int CNT_W = $clog2(route_fifo_depth + 1);

    logic             push_req, pop_req;
    logic             push_en, pop_en;
    logic             fifo_full, fifo_empty;
    logic             more_after_pop;
    logic [RW-1:0]    rd_data;
    logic [CNT_W-1:0] fifo_count;

    rh_state_e        state_q, state_d;
    logic [ERR_W-1:0] errors_q, errors_d;

    assign push_req = flit_valid_in & flit_head_in;
    assign pop_req  = flit_sent & flit_sent_tail;

    // Same acceptance rules as inside the FIFO; needed here for the FSM
    // and the error pulses.
    assign pop_en  = pop_req & ~fifo_empty;
    assign push_en = push_req & (~fifo_full | pop_en);

    // After a pop another route remains if more than one was queued or a
    // new head arrives in the same cycle.
    assign more_after_pop = (fifo_count > CNT_W'(1)) | push_en;

    rtr_route_fifo #(
        .WIDTH (RW),
        .DEPTH (route_fifo_depth)
    ) u_route_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_en),
        .push_data ({route_in_op, route_in_orc}),
        .pop       (pop_en),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Control FSM; a pop always wins over a simultaneous grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RH_IDLE: begin
                if (push_en) state_d = RH_WAIT_VC;
            end
            RH_WAIT_VC: begin
                if (pop_en)      state_d = more_after_pop ? RH_WAIT_VC : RH_IDLE;
                else if (vc_gnt) state_d = RH_ACTIVE;
            end
            RH_ACTIVE: begin
                if (pop_en)      state_d = more_after_pop ? RH_WAIT_VC : RH_IDLE;
            end
            default: state_d = RH_IDLE;
        endcase
    end

    always_comb begin
        errors_d                 = '0;
        errors_d[ERR_OVERFLOW]   = push_req & fifo_full & ~pop_en;
        errors_d[ERR_UNDERFLOW]  = pop_req & fifo_empty;
        errors_d[ERR_TAIL_NO_VC] = pop_req & (state_q == RH_WAIT_VC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RH_IDLE;
            errors_q <= '0;
        end else begin
            state_q  <= state_d;
            errors_q <= errors_d;
        end
    end

    assign route_valid = (state_q != RH_IDLE);
    assign vc_req      = (state_q == RH_WAIT_VC);
    assign route_op    = fifo_empty ? '0 : rd_data[RW-1 -: num_ports];
    assign route_orc   = fifo_empty ? '0 : rd_data[num_resource_classes-1:0];
    assign route_count = fifo_count;
    assign errors      = errors_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rtr_route_hold.sv
module tb_rtr_route_hold;
  import rtr_route_hold_pkg::*;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic       flit_valid_in, flit_head_in, vc_gnt, flit_sent, flit_sent_tail;
  logic [4:0] route_in_op;
  logic [1:0] route_in_orc;
  logic       route_valid, vc_req;
  logic [4:0] route_op;
  logic [1:0] route_orc;
  logic [1:0] route_count;
  logic [2:0] err;
  rh_state_e  dbg_state;

  rtr_route_hold dut (
    .clk            (clk),
    .reset          (reset),
    .flit_valid_in  (flit_valid_in),
    .flit_head_in   (flit_head_in),
    .route_in_op    (route_in_op),
    .route_in_orc   (route_in_orc),
    .vc_gnt         (vc_gnt),
    .flit_sent      (flit_sent),
    .flit_sent_tail (flit_sent_tail),
    .route_valid    (route_valid),
    .route_op       (route_op),
    .route_orc      (route_orc),
    .vc_req         (vc_req),
    .route_count    (route_count),
    .errors         (err),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] pack(logic v, logic [4:0] op, logic [1:0] orc,
                                       logic req, logic [1:0] cnt, logic [2:0] e,
                                       logic [1:0] st);
    return {v, op, orc, req, cnt, e, st};
  endfunction

  function automatic logic [15:0] dut_vec();
    return pack(route_valid, route_op, route_orc, vc_req, route_count, err, dbg_state);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got v=%b op=%b orc=%b req=%b cnt=%0d err=%b st=%0d exp v=%b op=%b orc=%b req=%b cnt=%0d err=%b st=%0d",
               name, got[15], got[14:10], got[9:8], got[7], got[6:5], got[4:2], got[1:0],
               exp[15], exp[14:10], exp[9:8], exp[7], exp[6:5], exp[4:2], exp[1:0]);
    end
  endtask

  // ---------------- reference model ----------------
  // A queue of packet routes plus one flag: does the head packet own a VC?
  logic [6:0] mq[$];
  bit         m_held;
  logic [2:0] m_err;

  function automatic void model_reset();
    mq.delete();
    m_held = 1'b0;
    m_err  = '0;
  endfunction

  function automatic void model_step(logic v, logic h, logic [4:0] op, logic [1:0] orc,
                                     logic g, logic s, logic t);
    int sz;
    bit pop_req, push_req, pop_ok;
    sz       = mq.size();
    pop_req  = s && t;
    push_req = v && h;
    pop_ok   = pop_req && (sz > 0);
    m_err    = '0;
    if (pop_req && sz == 0)                   m_err[1] = 1'b1;
    if (pop_ok && !m_held)                    m_err[2] = 1'b1;
    if (push_req && sz == DEPTH && !pop_ok)   m_err[0] = 1'b1;
    if (pop_ok) begin
      void'(mq.pop_front());
      m_held = 1'b0;
    end else if (g && sz > 0 && !m_held) begin
      m_held = 1'b1;
    end
    if (push_req && (sz < DEPTH || pop_ok)) mq.push_back({op, orc});
  endfunction

  function automatic logic [15:0] model_vec();
    logic [6:0] hd;
    logic [1:0] st;
    hd = (mq.size() > 0) ? mq[0] : 7'd0;
    if (mq.size() == 0) st = RH_IDLE;
    else if (m_held)    st = RH_ACTIVE;
    else                st = RH_WAIT_VC;
    return pack(mq.size() > 0, hd[6:2], hd[1:0], (mq.size() > 0) && !m_held,
                2'(mq.size()), m_err, st);
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input logic v, input logic h, input logic [4:0] op, input logic [1:0] orc,
                       input logic g, input logic s, input logic t);
    flit_valid_in  = v;
    flit_head_in   = h;
    route_in_op    = op;
    route_in_orc   = orc;
    vc_gnt         = g;
    flit_sent      = s;
    flit_sent_tail = t;
    @(posedge clk);
    model_step(v, h, op, orc, g, s, t);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v, h;
    logic [4:0] op;
    logic [1:0] orc;
    logic       g, s, t;
    logic       ev;
    logic [4:0] eop;
    logic [1:0] eorc;
    logic       ereq;
    logic [1:0] ecnt;
    logic [2:0] eerr;
    rh_state_e  est;
  } vec_t;

  function automatic vec_t mk(logic v, logic h, logic [4:0] op, logic [1:0] orc,
                              logic g, logic s, logic t,
                              logic ev, logic [4:0] eop, logic [1:0] eorc, logic ereq,
                              logic [1:0] ecnt, logic [2:0] eerr, rh_state_e est);
    vec_t r;
    r.v = v; r.h = h; r.op = op; r.orc = orc; r.g = g; r.s = s; r.t = t;
    r.ev = ev; r.eop = eop; r.eorc = eorc; r.ereq = ereq;
    r.ecnt = ecnt; r.eerr = eerr; r.est = est;
    return r;
  endfunction

  localparam int NV = 29;
  vec_t tbl[NV];

  initial begin
    reset          = 1'b0;
    flit_valid_in  = 1'b0;
    flit_head_in   = 1'b0;
    route_in_op    = '0;
    route_in_orc   = '0;
    vc_gnt         = 1'b0;
    flit_sent      = 1'b0;
    flit_sent_tail = 1'b0;
    model_reset();

    //            v h op        orc   g s t   ev eop       eorc  rq cnt eerr    state
    // single packet: head, body, grant at t+3, tail at t+6
    tbl[0]  = mk(0,0,5'b00000,2'b00, 0,0,0,  0,5'b00000,2'b00, 0,2'd0,3'b000, RH_IDLE);
    tbl[1]  = mk(1,1,5'b00100,2'b01, 0,0,0,  1,5'b00100,2'b01, 1,2'd1,3'b000, RH_WAIT_VC);
    tbl[2]  = mk(1,0,5'b00000,2'b00, 0,0,0,  1,5'b00100,2'b01, 1,2'd1,3'b000, RH_WAIT_VC);
    tbl[3]  = mk(0,0,5'b00000,2'b00, 0,0,0,  1,5'b00100,2'b01, 1,2'd1,3'b000, RH_WAIT_VC);
    tbl[4]  = mk(0,0,5'b00000,2'b00, 1,0,0,  1,5'b00100,2'b01, 0,2'd1,3'b000, RH_ACTIVE);
    tbl[5]  = mk(0,0,5'b00000,2'b00, 0,1,0,  1,5'b00100,2'b01, 0,2'd1,3'b000, RH_ACTIVE);
    tbl[6]  = mk(0,0,5'b00000,2'b00, 0,1,0,  1,5'b00100,2'b01, 0,2'd1,3'b000, RH_ACTIVE);
    tbl[7]  = mk(0,0,5'b00000,2'b00, 0,1,1,  0,5'b00000,2'b00, 0,2'd0,3'b000, RH_IDLE);
    // two heads queued, third head overflows
    tbl[8]  = mk(1,1,5'b00010,2'b10, 0,0,0,  1,5'b00010,2'b10, 1,2'd1,3'b000, RH_WAIT_VC);
    tbl[9]  = mk(1,1,5'b01000,2'b01, 0,0,0,  1,5'b00010,2'b10, 1,2'd2,3'b000, RH_WAIT_VC);
    tbl[10] = mk(1,1,5'b10000,2'b01, 0,0,0,  1,5'b00010,2'b10, 1,2'd2,3'b001, RH_WAIT_VC);
    tbl[11] = mk(0,0,5'b00000,2'b00, 0,0,0,  1,5'b00010,2'b10, 1,2'd2,3'b000, RH_WAIT_VC);
    tbl[12] = mk(0,0,5'b00000,2'b00, 1,0,0,  1,5'b00010,2'b10, 0,2'd2,3'b000, RH_ACTIVE);
    tbl[13] = mk(0,0,5'b00000,2'b00, 0,1,1,  1,5'b01000,2'b01, 1,2'd1,3'b000, RH_WAIT_VC);
    // full FIFO with simultaneous head-in and tail-out
    tbl[14] = mk(1,1,5'b00001,2'b10, 0,0,0,  1,5'b01000,2'b01, 1,2'd2,3'b000, RH_WAIT_VC);
    tbl[15] = mk(0,0,5'b00000,2'b00, 1,0,0,  1,5'b01000,2'b01, 0,2'd2,3'b000, RH_ACTIVE);
    tbl[16] = mk(1,1,5'b10000,2'b10, 0,1,1,  1,5'b00001,2'b10, 1,2'd2,3'b000, RH_WAIT_VC);
    tbl[17] = mk(0,0,5'b00000,2'b00, 1,0,0,  1,5'b00001,2'b10, 0,2'd2,3'b000, RH_ACTIVE);
    tbl[18] = mk(0,0,5'b00000,2'b00, 0,1,1,  1,5'b10000,2'b10, 1,2'd1,3'b000, RH_WAIT_VC);
    // tail in WAIT_VC, then tail when empty
    tbl[19] = mk(0,0,5'b00000,2'b00, 0,1,1,  0,5'b00000,2'b00, 0,2'd0,3'b100, RH_IDLE);
    tbl[20] = mk(0,0,5'b00000,2'b00, 0,1,1,  0,5'b00000,2'b00, 0,2'd0,3'b010, RH_IDLE);
    tbl[21] = mk(0,0,5'b00000,2'b00, 0,0,0,  0,5'b00000,2'b00, 0,2'd0,3'b000, RH_IDLE);
    // grant while IDLE is ignored, also in the cycle of the head
    tbl[22] = mk(0,0,5'b00000,2'b00, 1,0,0,  0,5'b00000,2'b00, 0,2'd0,3'b000, RH_IDLE);
    tbl[23] = mk(1,1,5'b00100,2'b01, 1,0,0,  1,5'b00100,2'b01, 1,2'd1,3'b000, RH_WAIT_VC);
    tbl[24] = mk(0,0,5'b00000,2'b00, 1,0,0,  1,5'b00100,2'b01, 0,2'd1,3'b000, RH_ACTIVE);
    // single-flit packet queued behind the active one
    tbl[25] = mk(1,1,5'b00001,2'b01, 0,0,0,  1,5'b00100,2'b01, 0,2'd2,3'b000, RH_ACTIVE);
    tbl[26] = mk(0,0,5'b00000,2'b00, 0,1,1,  1,5'b00001,2'b01, 1,2'd1,3'b000, RH_WAIT_VC);
    tbl[27] = mk(0,0,5'b00000,2'b00, 1,0,0,  1,5'b00001,2'b01, 0,2'd1,3'b000, RH_ACTIVE);
    tbl[28] = mk(0,0,5'b00000,2'b00, 0,1,1,  0,5'b00000,2'b00, 0,2'd0,3'b000, RH_IDLE);

    // reset held for a few cycles: everything must read 0
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 16'h0000);
    reset = 1'b1;

    // table phase
    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].v, tbl[i].h, tbl[i].op, tbl[i].orc, tbl[i].g, tbl[i].s, tbl[i].t);
      check($sformatf("vec%0d", i), dut_vec(),
            pack(tbl[i].ev, tbl[i].eop, tbl[i].eorc, tbl[i].ereq, tbl[i].ecnt,
                 tbl[i].eerr, tbl[i].est));
      check($sformatf("vec%0d_model", i), dut_vec(), model_vec());
    end

    // async reset in ACTIVE with two routes queued
    apply(1, 1, 5'b00010, 2'b10, 0, 0, 0);
    apply(1, 1, 5'b01000, 2'b01, 0, 0, 0);
    apply(0, 0, 5'b00000, 2'b00, 1, 0, 0);
    check("pre_reset_active", dut_vec(),
          pack(1, 5'b00010, 2'b10, 0, 2'd2, 3'b000, RH_ACTIVE));
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_immediate", dut_vec(), 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(0, 0, 5'b00000, 2'b00, 1, 1, 0);
    check("after_reset_idle", dut_vec(),
          pack(0, 5'b00000, 2'b00, 0, 2'd0, 3'b000, RH_IDLE));
    check("after_reset_model", dut_vec(), model_vec());

    // randomized phase against the model
    for (int c = 0; c < 800; c++) begin
      logic v, h, g, s, t;
      logic [4:0] op;
      logic [1:0] orc;
      v   = ($urandom_range(0, 2) != 0);
      h   = v && ($urandom_range(0, 2) == 0);
      op  = 5'(1 << $urandom_range(0, 4));
      orc = 2'(1 << $urandom_range(0, 1));
      g   = ($urandom_range(0, 2) == 0);
      s   = ($urandom_range(0, 1) == 0);
      t   = s && ($urandom_range(0, 3) == 0);
      apply(v, h, op, orc, g, s, t);
      check($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
